// File: rtl/monitor_pio_edge_in.sv
`default_nettype none
// ============================================================================
// Module   : monitor_pio_edge_in
// Purpose  : Avalon-MM slave input port for the monitor CPU. Samples an
//            external WIDTH-bit bus through a synchroniser, latches selected
//            edges into a sticky capture register and raises a maskable
//            level interrupt.
// Ports    : clk, reset_n        - system clock, async active-low reset
//            address[1:0]        - register select (0 DATA, 1 rsvd,
//                                  2 IRQMASK, 3 EDGECAP)
//            chipselect, read_n, write_n, writedata[31:0] - Avalon-MM slave
//            in_port[WIDTH-1:0]  - asynchronous external inputs
//            readdata[31:0]      - registered read data (latency 1)
//            irq                 - active-high level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module monitor_pio_edge_in #(
    parameter int WIDTH       = 8,   // 1..32
    parameter int EDGE_TYPE   = 0,   // 0 rising, 1 falling, 2 any
    parameter int SYNC_STAGES = 2    // 2..4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] c_ADDR_DATA    = 2'd0;
    localparam logic [1:0] c_ADDR_MASK    = 2'd2;
    localparam logic [1:0] c_ADDR_EDGECAP = 2'd3;
    // Edges are ignored until the chain and prev stage hold real samples.
    localparam logic [2:0] c_PRIME_CYCLES = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  r_cap;
    logic [WIDTH-1:0]                  r_mask;
    logic [2:0]                        r_prime_cnt;

    logic [WIDTH-1:0] w_data_q;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_primed;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_data_q = r_sync[SYNC_STAGES-1];
    assign w_wr_en  = chipselect && !write_n;
    assign w_rd_en  = chipselect && !read_n;
    assign w_primed = (r_prime_cnt == c_PRIME_CYCLES);

    // Bits of writedata above WIDTH are architecturally ignored.
    assign w_unused_wdata = &{1'b0, writedata};

    // ------------------------------------------------------------------
    // Synchroniser chain and one-cycle delayed copy of its output
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_data_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prime_cnt <= '0;
        end else if (!w_primed) begin
            r_prime_cnt <= r_prime_cnt + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Edge detector selected at elaboration time
    // ------------------------------------------------------------------
    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge_raw = w_data_q & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge_raw = ~w_data_q & r_prev;
        end else begin : g_edge_any
            assign w_edge_raw = w_data_q ^ r_prev;
        end
    endgenerate

    assign w_edge = w_primed ? w_edge_raw : '0;
    assign w_clr  = (w_wr_en && (address == c_ADDR_EDGECAP)) ?
                    writedata[WIDTH-1:0] : '0;

    // ------------------------------------------------------------------
    // Capture, mask and interrupt registers. Set beats clear on collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap  <= '0;
            r_mask <= '0;
            irq    <= 1'b0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_edge;
            if (w_wr_en && (address == c_ADDR_MASK)) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            irq <= |(r_cap & r_mask);
        end
    end

    // ------------------------------------------------------------------
    // Read path: registered, side-effect free, pre-write values
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_data_q;
            c_ADDR_MASK:    w_rd_mux[WIDTH-1:0] = r_mask;
            c_ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_cap;
            default:        w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (w_rd_en) begin
            readdata <= w_rd_mux;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_monitor_pio_edge_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_monitor_pio_edge_in
// Purpose  : Directed self-checking bench. Three instances (rising, falling,
//            any-edge) share one bus and one input port; each scenario task
//            checks its own expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_monitor_pio_edge_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;
    logic [31:0] v0, v1, v2;

    int n_cmp;
    int n_bad;

    monitor_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd0), .irq(irq0));

    monitor_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd1), .irq(irq1));

    monitor_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd2), .irq(irq2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single read strobe; readdata is sampled just after the strobing edge.
    task automatic do_read(input logic [1:0] a,
                           output logic [31:0] r0, output logic [31:0] r1,
                           output logic [31:0] r2);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
        r0 = rd0; r1 = rd1; r2 = rd2;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if ({irq0, irq1, irq2} !== 3'b000) begin n_bad++;
            $display("FAIL reset_irq_during: got %b want 000", {irq0, irq1, irq2}); end
        n_cmp++; if (rd0 !== 32'h0) begin n_bad++;
            $display("FAIL reset_rd_during: got %h want 00000000", rd0); end
        tick(); tick();
        reset_n = 1'b1;
        repeat (10) tick();
        n_cmp++; if ({irq0, irq1, irq2} !== 3'b000) begin n_bad++;
            $display("FAIL reset_irq_after: got %b want 000", {irq0, irq1, irq2}); end
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if ({v0, v1, v2} !== 96'h0) begin n_bad++;
            $display("FAIL reset_edgecap: got %h %h %h want 0 0 0", v0, v1, v2); end
        do_read(2'd0, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h000000FF) begin n_bad++;
            $display("FAIL reset_data: got %h want 000000FF", v0); end
        do_read(2'd2, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h0) begin n_bad++;
            $display("FAIL reset_mask: got %h want 00000000", v0); end
        do_read(2'd1, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h0) begin n_bad++;
            $display("FAIL reserved_read: got %h want 00000000", v0); end
    endtask

    task automatic test_rising_irq();
        in_port = 8'h00;
        repeat (4) tick();
        do_write(2'd3, 32'hFF);
        do_write(2'd2, 32'h08);
        in_port = 8'h08;                // toggles before edge N
        tick();                         // N
        tick();                         // N+1
        address = 2'd3; chipselect = 1'b1; read_n = 1'b0;
        tick();                         // N+2: read returns pre-set value
        n_cmp++; if (rd0 !== 32'h0) begin n_bad++;
            $display("FAIL rise_cap_n2: got %h want 00000000", rd0); end
        n_cmp++; if (irq0 !== 1'b0) begin n_bad++;
            $display("FAIL rise_irq_n2: got %b want 0", irq0); end
        tick();                         // N+3
        chipselect = 1'b0; read_n = 1'b1;
        n_cmp++; if (rd0 !== 32'h08) begin n_bad++;
            $display("FAIL rise_cap_n3: got %h want 00000008", rd0); end
        n_cmp++; if (irq0 !== 1'b1) begin n_bad++;
            $display("FAIL rise_irq_n3: got %b want 1", irq0); end
        n_cmp++; if (irq1 !== 1'b0) begin n_bad++;
            $display("FAIL fall_no_rise_irq: got %b want 0", irq1); end
        do_write(2'd3, 32'h08);         // clear at M
        n_cmp++; if (irq0 !== 1'b1) begin n_bad++;
            $display("FAIL clr_irq_m: got %b want 1", irq0); end
        tick();                         // M+1
        n_cmp++; if (irq0 !== 1'b0) begin n_bad++;
            $display("FAIL clr_irq_m1: got %b want 0", irq0); end
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h0) begin n_bad++;
            $display("FAIL clr_cap: got %h want 00000000", v0); end
    endtask

    task automatic test_masked();
        do_write(2'd2, 32'h0);
        in_port = 8'h00;
        repeat (4) tick();
        do_write(2'd3, 32'hFF);
        in_port = 8'h08;
        repeat (4) tick();
        n_cmp++; if (irq0 !== 1'b0) begin n_bad++;
            $display("FAIL masked_irq: got %b want 0", irq0); end
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h08) begin n_bad++;
            $display("FAIL masked_cap: got %h want 00000008", v0); end
        do_write(2'd2, 32'h08);         // mask at M
        n_cmp++; if (irq0 !== 1'b0) begin n_bad++;
            $display("FAIL unmask_irq_m: got %b want 0", irq0); end
        tick();
        n_cmp++; if (irq0 !== 1'b1) begin n_bad++;
            $display("FAIL unmask_irq_m1: got %b want 1", irq0); end
    endtask

    task automatic test_clear_collision();
        in_port = 8'h00;
        repeat (4) tick();
        in_port = 8'h08;
        tick();                         // N
        tick();                         // N+1
        address = 2'd3; writedata = 32'h08; chipselect = 1'b1; write_n = 1'b0;
        tick();                         // N+2: clear and set together
        chipselect = 1'b0; write_n = 1'b1;
        tick();                         // N+3
        n_cmp++; if (irq0 !== 1'b1) begin n_bad++;
            $display("FAIL collide_irq: got %b want 1", irq0); end
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h08) begin n_bad++;
            $display("FAIL collide_cap: got %h want 00000008", v0); end
        do_write(2'd3, 32'h08);
        tick();
        n_cmp++; if (irq0 !== 1'b0) begin n_bad++;
            $display("FAIL collide_after_clr: got %b want 0", irq0); end
    endtask

    task automatic test_any_edge();
        do_write(2'd3, 32'hFF);
        do_write(2'd2, 32'h01);
        in_port = 8'h09;                // bit0 0->1
        repeat (5) tick();
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if ({v0, v1, v2} !== {32'h01, 32'h00, 32'h01}) begin n_bad++;
            $display("FAIL any_rise_cap: got %h %h %h want 01 00 01", v0, v1, v2); end
        n_cmp++; if ({irq1, irq2} !== 2'b01) begin n_bad++;
            $display("FAIL any_rise_irq: got %b want 01", {irq1, irq2}); end
        tick();
        n_cmp++; if (rd2 !== 32'h01) begin n_bad++;
            $display("FAIL rd_hold: got %h want 00000001", rd2); end
        do_write(2'd3, 32'h01);
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if (v2 !== 32'h0) begin n_bad++;
            $display("FAIL any_clr_cap: got %h want 00000000", v2); end
        n_cmp++; if (irq2 !== 1'b0) begin n_bad++;
            $display("FAIL any_clr_irq: got %b want 0", irq2); end
        in_port = 8'h08;                // bit0 1->0
        repeat (5) tick();
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if ({v0, v1, v2} !== {32'h00, 32'h01, 32'h01}) begin n_bad++;
            $display("FAIL any_fall_cap: got %h %h %h want 00 01 01", v0, v1, v2); end
        n_cmp++; if ({irq0, irq1, irq2} !== 3'b011) begin n_bad++;
            $display("FAIL any_fall_irq: got %b want 011", {irq0, irq1, irq2}); end
        do_write(2'd3, 32'h01);
        in_port = 8'h09;                // bit0 0->1 again
        repeat (5) tick();
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if ({v0, v1, v2} !== {32'h01, 32'h00, 32'h01}) begin n_bad++;
            $display("FAIL any_rise2_cap: got %h %h %h want 01 00 01", v0, v1, v2); end
    endtask

    task automatic test_rw_same_cycle();
        address = 2'd2; writedata = 32'hFFFFFF5A;
        chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        n_cmp++; if (rd0 !== 32'h01) begin n_bad++;
            $display("FAIL rw_pre_value: got %h want 00000001", rd0); end
        do_read(2'd2, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h5A) begin n_bad++;
            $display("FAIL mask_upper_ignored: got %h want 0000005A", v0); end
        do_read(2'd3, v0, v1, v2);
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h01) begin n_bad++;
            $display("FAIL read_no_side_effect: got %h want 00000001", v0); end
    endtask

    task automatic test_reset_mid();
        do_write(2'd3, 32'hFF);
        do_write(2'd2, 32'hFF);
        do_read(2'd0, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h09) begin n_bad++;
            $display("FAIL pre_rst_data: got %h want 00000009", v0); end
        in_port = 8'h0D;                // bit2 rising
        repeat (4) tick();
        n_cmp++; if (irq0 !== 1'b1) begin n_bad++;
            $display("FAIL pre_rst_irq: got %b want 1", irq0); end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if ({irq0, irq1, irq2} !== 3'b000) begin n_bad++;
            $display("FAIL async_rst_irq: got %b want 000", {irq0, irq1, irq2}); end
        n_cmp++; if ({rd0, rd1, rd2} !== 96'h0) begin n_bad++;
            $display("FAIL async_rst_rd: got %h %h %h want 0 0 0", rd0, rd1, rd2); end
        in_port = 8'hF0;
        tick(); tick();
        reset_n = 1'b1;
        repeat (10) tick();
        n_cmp++; if ({irq0, irq1, irq2} !== 3'b000) begin n_bad++;
            $display("FAIL prime_irq: got %b want 000", {irq0, irq1, irq2}); end
        do_read(2'd3, v0, v1, v2);
        n_cmp++; if ({v0, v1, v2} !== 96'h0) begin n_bad++;
            $display("FAIL prime_cap: got %h %h %h want 0 0 0", v0, v1, v2); end
        do_read(2'd2, v0, v1, v2);
        n_cmp++; if (v0 !== 32'h0) begin n_bad++;
            $display("FAIL rst_mask: got %h want 00000000", v0); end
        do_read(2'd0, v0, v1, v2);
        n_cmp++; if (v0 !== 32'hF0) begin n_bad++;
            $display("FAIL rst_data: got %h want 000000F0", v0); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0;
        read_n = 1'b1; write_n = 1'b1; writedata = 32'h0; in_port = 8'hFF;
        test_reset();
        test_rising_irq();
        test_masked();
        test_clear_collision();
        test_any_edge();
        test_rw_same_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/monitor_pio_edge_in.md
# monitor_pio_edge_in

Avalon-MM slave input port for the monitor CPU: it samples an external WIDTH-bit bus, synchronises it into `clk`, latches selected edges into a sticky capture register and raises a maskable, level interrupt. It is the read-side counterpart of the monitor's single-bit output PIOs. Board-side status lines (target clock echo, halt/ready flags, push buttons) feed the monitor through it, and software polls or takes interrupts via the CPU data bus.

## Interface
Parameters:
- `WIDTH`, 8, input bus width, 1..32
- `EDGE_TYPE`, 0, captured edge: 0 rising, 1 falling, 2 any
- `SYNC_STAGES`, 2, synchroniser flops on `in_port`, 2..4

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `address`  in  2  register select
- `chipselect`  in  1  slave select
- `read_n`  in  1  read strobe, active-low
- `write_n`  in  1  write strobe, active-low
- `writedata`  in  32  write data
- `in_port`  in  WIDTH  asynchronous external inputs
- `readdata`  out  32  registered read data
- `irq`  out  1  interrupt request, active-high level

## Operation
- Register map (upper bits above WIDTH read 0, writes ignored):
  - 0 DATA: synchronised `in_port`, read-only.
  - 1 reserved: reads 0.
  - 2 IRQMASK: read/write, reset 0.
  - 3 EDGECAP: sticky edge flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- Synchroniser: a SYNC_STAGES-deep flop chain per bit. `data_q` is the last stage, and `prev_q` is `data_q` delayed by one cycle.
- Edge detection per bit:
  - rising: `data_q & ~prev_q`
  - falling: `~data_q & prev_q`
  - any: XOR of `data_q` and `prev_q`
- Priming: a counter suppresses edge detection until the chain and `prev_q` have filled, i.e. SYNC_STAGES+1 cycles after reset deassertion. Inputs that are static across reset therefore never produce a capture.
- EDGECAP update: `cap <= (cap & ~clr) | edge`. If an edge and a clear of the same bit occur in the same cycle, the set wins and the bit ends at 1.
- `irq` is a register, updated every cycle as `|(cap & IRQMASK)`. It is a level, held until the bits are cleared or masked.
- Writes take effect on the cycle where `chipselect && !write_n`.
- Reads are captured into `readdata` on the cycle where `chipselect && !read_n`. `readdata` holds its value otherwise.
- Reads have no side effects: reading EDGECAP does not clear it.

## Timing
- Reset values: every synchroniser stage, `prev_q`, EDGECAP, IRQMASK, the priming counter, `readdata` and `irq` are 0.
- Read latency is 1: data for a read strobed at edge N appears on `readdata` after edge N and is valid at edge N+1. There are no wait states.
- Input to DATA latency (`in_port` stable before edge N):
  - with SYNC_STAGES = S, `data_q` reflects the input after edge N+S-1.
  - a read strobed at edge N+S returns the new value.
- Edge path (S = 2, input toggles before edge N):
  - `data_q` changes at N+1.
  - EDGECAP bit sets at N+2.
  - `irq` asserts at N+3, provided the mask bit is set.
- Clear path: an EDGECAP write at edge M clears the bit at M. `irq` deasserts at M+1 if no other masked bit remains set.
- Mask path: an IRQMASK write at M gives an `irq` change at M+1.
- Simultaneous read and write in one cycle: the read returns the pre-write register value.
- Input pulses shorter than one `clk` period may be missed. This is not an error.
- Asserting reset mid-operation clears all state immediately. Priming restarts after release.

## Test plan
- Reset release with `in_port=8'hFF`, EDGE_TYPE=0: after 10 cycles, EDGECAP=0, `irq`=0, and a DATA read returns `32'h000000FF`.
- Rising edge on bit 3 at edge N with IRQMASK=`8'h08`: EDGECAP=`8'h08` at N+2, `irq`=1 at N+3. Writing `32'h08` to address 3 drops `irq` one cycle later.
- Same edge with IRQMASK=0: EDGECAP=`8'h08` and `irq` stays 0. Writing IRQMASK=`8'h08` then raises `irq` the next cycle.
- Clear of bit 3 in the same cycle as a new bit-3 edge: the bit remains 1 and `irq` stays asserted.
- EDGE_TYPE=2, bit 0 toggled 0→1→0 with 5-cycle spacing: each toggle sets EDGECAP[0] again after a clear between them. A 1-cycle read latency is checked on every read.
- Reset asserted one cycle after a capture: all outputs are 0 asynchronously, and there is no capture during the SYNC_STAGES+1 priming cycles after release.
